sram_ctrl: RTL and testbench
============================

# sram_ctrl

Synchronous initiator for the team's 2048x8 asynchronous SRAM (CY7C128A-style, active-low chip enable, write enable and output enable). It accepts single read or write requests from user logic over a valid/ready handshake. It then sequences the SRAM control pins through setup, access and hold phases, each lasting a parameterized number of cycles, and returns read data with a one-cycle response strobe. It sits between system logic and the SRAM pins. It is the only block that drives those pins.

## Interface
- ADDR_W, 11, SRAM address width (2048 words)
- DATA_W, 8, SRAM data width
- SETUP_CYC, 1, cycles with address/CE asserted before the strobe; legal range 1..15
- ACCESS_CYC, 2, cycles the WE or OE strobe is held low; legal range 1..15
- HOLD_CYC, 1, cycles after the strobe with address/data/CE held; legal range 1..15

Ports (name, direction, width, meaning):
- clk  in  1  the single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  a request is present
- req_ready  out  1  controller can accept a request; high only in IDLE
- req_write  in  1  1 = write, 0 = read; sampled at accept
- req_addr  in  ADDR_W  request address; sampled at accept
- req_wdata  in  DATA_W  write data; sampled at accept when req_write=1
- rsp_valid  out  1  one-cycle pulse: rsp_rdata holds read result
- rsp_rdata  out  DATA_W  captured read data; held until the next read capture
- sram_addr  out  ADDR_W  SRAM address pins
- sram_wdata  out  DATA_W  SRAM data_in pins
- sram_rdata  in  DATA_W  SRAM data_out pins
- sram_ce_n  out  1  chip enable, active low
- sram_we_n  out  1  write enable, active low
- sram_oe_n  out  1  output enable, active low

## Operation
- All outputs are registered; no combinational path from inputs to SRAM pins.
- The FSM has four states: IDLE, SETUP, ACCESS, HOLD. Each non-IDLE state counts its parameter in cycles using a 4-bit down-counter.
- Accept: a request is accepted on an edge where req_valid & req_ready. The controller latches req_write, req_addr and req_wdata (write only; sram_wdata is unchanged on reads), then moves IDLE to SETUP.
- Requests presented while req_ready=0 are ignored, not queued.
- SETUP: sram_ce_n=0, sram_we_n=1, sram_oe_n=1; sram_addr and sram_wdata are valid.
- ACCESS: sram_ce_n=0. On a write, sram_we_n=0. On a read, sram_oe_n=0.
- HOLD: sram_ce_n=0, sram_we_n=1, sram_oe_n=1; sram_addr and sram_wdata are held.
- HOLD returns to IDLE. In IDLE, sram_ce_n=1 and req_ready=1.
- Read capture: sram_rdata is registered into rsp_rdata on the edge that ends the last ACCESS cycle. rsp_valid is high for exactly the first HOLD cycle.
- Writes produce no response.
- Invariant: sram_we_n and sram_oe_n are never both low. Neither strobe is low while sram_ce_n=1.
- sram_addr and sram_wdata change only on the accept edge. They are stable for the entire SETUP through HOLD window.

## Timing
- With accept at edge E0 and defaults 1/2/1:
  - cycle 1: SETUP
  - cycles 2-3: ACCESS (strobe low)
  - cycle 4: HOLD, with rsp_valid=1 for reads
  - cycle 5: IDLE, req_ready=1
- General latency, accept to IDLE: SETUP_CYC + ACCESS_CYC + HOLD_CYC + 1 cycles. The next accept is possible at the end of that IDLE cycle.
- Read latency, accept edge to rsp_valid: SETUP_CYC + ACCESS_CYC + 1 cycles.
- Reset values, asserted the cycle after any edge with reset=1:
  - sram_ce_n = sram_we_n = sram_oe_n = 1
  - sram_addr = 0, sram_wdata = 0
  - rsp_rdata = 0, rsp_valid = 0
  - req_ready = 0 while reset is high
  - state = IDLE, counter = 0
- req_ready rises in the first cycle after reset deasserts.
- Reset mid-transaction: the operation is aborted and all strobes go high after the reset edge. An aborted read produces no rsp_valid. A write aborted during ACCESS may leave that SRAM word undefined.
- Reset takes priority over acceptance. A req_valid on the same edge as reset=1 is dropped.

## Test plan
Each test line reads: stimulus -> required response. The bench instantiates the team's 2048x8 SRAM model on the sram_* pins.

- Reset: hold reset 2 cycles -> all pins at reset values, req_ready=0; one cycle after release, req_ready=1.
- Write then read: write 0xA5 @0x000, then read @0x000 (defaults) -> sram_we_n low exactly cycles 2-3 after accept, rsp_valid cycle 4 with rsp_rdata=0xA5, req_ready back cycle 5.
- Boundary address: write 0x3C @0x7FF, write 0xC3 @0x001, read both -> 0x3C and 0xC3; read @0x000 still 0xA5.
- Busy ignore: hold req_valid=1 with a new read @0x7FF throughout a write -> it is accepted only at the next IDLE; exactly one transaction per accept; WE/OE never both low.
- Reset mid-read: assert reset during the first ACCESS cycle -> all strobes high the next cycle, no rsp_valid; after release, read @0x000 -> 0xA5.
- Parameter sweep SETUP_CYC=2, ACCESS_CYC=4, HOLD_CYC=3 -> strobe low 4 cycles, rsp_valid 7 cycles after accept, req_ready after 10 cycles.

Source files
------------

// File: rtl/sram_ctrl.sv
// Synchronous initiator for a 2048x8 asynchronous SRAM: sequences CE/WE/OE through
// setup, access and hold phases for single read/write requests.
module sram_ctrl #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned ACCESS_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             is_write;
    logic             is_write_nxt;
    logic             accept_c;
    logic             capture_c;

    // req_ready is only high in IDLE, so this alone qualifies an accept
    assign accept_c = req_valid && req_ready;

    // Next-state: each phase loads its length minus one and leaves when the counter hits zero
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        is_write_nxt = is_write;
        capture_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_nxt    = ST_SETUP;
                    cnt_nxt      = SETUP_LD;
                    is_write_nxt = req_write;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_ACCESS;
                    cnt_nxt   = ACCESS_LD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LD;
                    capture_c = !is_write;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register; pin outputs are decoded from the next state so they are flop outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            is_write   <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            is_write  <= is_write_nxt;
            req_ready <= (state_nxt == ST_IDLE);
            sram_ce_n <= (state_nxt == ST_IDLE);
            sram_we_n <= !((state_nxt == ST_ACCESS) && is_write_nxt);
            sram_oe_n <= !((state_nxt == ST_ACCESS) && !is_write_nxt);
            rsp_valid <= capture_c;
            if (capture_c) begin
                rsp_rdata <= sram_rdata;
            end
            if (accept_c) begin
                sram_addr <= req_addr;
                if (req_write) begin
                    sram_wdata <= req_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default-timing and 2/4/3-timing instances, each on its own SRAM model.
module tb_sram_ctrl;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;
    localparam int S0 = 1, A0 = 2, H0 = 1;
    localparam int S1 = 2, A1 = 4, H1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         rst       = 2'b11;
    logic [1:0]         req_valid = 2'b00;
    logic [1:0]         req_write = 2'b00;
    logic [1:0][AW-1:0] req_addr  = '0;
    logic [1:0][DW-1:0] req_wdata = '0;
    wire  [1:0]         req_ready, rsp_valid, ce_n, we_n, oe_n;
    wire  [1:0][DW-1:0] rsp_rdata, sram_wdata, sram_rdata;
    wire  [1:0][AW-1:0] sram_addr;

    logic [DW-1:0] mem0 [2048] = '{default: '0};
    logic [DW-1:0] mem1 [2048] = '{default: '0};
    logic [DW-1:0] ref_mem [2][2048] = '{default: '0};
    logic [DW-1:0] exp_wdata [2] = '{default: '0};
    logic [DW-1:0] exp_rdata [2] = '{default: '0};
    int ncmp  = 0;
    int nfail = 0;

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S0), .ACCESS_CYC(A0), .HOLD_CYC(H0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .sram_addr(sram_addr[0]),
        .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]), .sram_ce_n(ce_n[0]),
        .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0])
    );

    sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S1), .ACCESS_CYC(A1), .HOLD_CYC(H1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .sram_addr(sram_addr[1]),
        .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]), .sram_ce_n(ce_n[1]),
        .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1])
    );

    // Asynchronous SRAM models: data out while CE and OE low, write while CE and WE low
    assign sram_rdata[0] = (!ce_n[0] && !oe_n[0]) ? mem0[sram_addr[0]] : '0;
    assign sram_rdata[1] = (!ce_n[1] && !oe_n[1]) ? mem1[sram_addr[1]] : '0;
    always @(posedge clk) if (ce_n[0] === 1'b0 && we_n[0] === 1'b0) mem0[sram_addr[0]] <= sram_wdata[0];
    always @(posedge clk) if (ce_n[1] === 1'b0 && we_n[1] === 1'b0) mem1[sram_addr[1]] <= sram_wdata[1];

    function automatic int s_of(input int d); return (d == 0) ? S0 : S1; endfunction
    function automatic int a_of(input int d); return (d == 0) ? A0 : A1; endfunction
    function automatic int h_of(input int d); return (d == 0) ? H0 : H1; endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, d, $time, obs, exp);
        end
    endtask

    task automatic chk_pins_reset(input int d);
        chk("rst_ce_n", d, 32'(ce_n[d]), 32'd1);
        chk("rst_we_n", d, 32'(we_n[d]), 32'd1);
        chk("rst_oe_n", d, 32'(oe_n[d]), 32'd1);
        chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
        chk("rst_ready", d, 32'(req_ready[d]), 32'd0);
    endtask

    task automatic do_reset(input int d, input int cycles);
        @(negedge clk);
        rst[d] = 1'b1;
        repeat (cycles) @(negedge clk);
        chk_pins_reset(d);
        chk("rst_addr", d, 32'(sram_addr[d]), 32'd0);
        chk("rst_wdata", d, 32'(sram_wdata[d]), 32'd0);
        chk("rst_rdata", d, 32'(rsp_rdata[d]), 32'd0);
        rst[d] = 1'b0;
        exp_wdata[d] = '0;
        exp_rdata[d] = '0;
        chk("rel_ready_low", d, 32'(req_ready[d]), 32'd0);
        @(negedge clk);
        chk("rel_ready_high", d, 32'(req_ready[d]), 32'd1);
    endtask

    // One transaction, checked every cycle from accept back to IDLE against the phase arithmetic.
    // With busy set, a read of busy_a is held on the request port for the whole transaction.
    task automatic txn(input int d, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input bit busy, input logic [AW-1:0] busy_a);
        int s, ac, lat, n;
        bit strobe, idle;
        s   = s_of(d);
        ac  = a_of(d);
        lat = s + ac + h_of(d) + 1;
        n   = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", d, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        @(posedge clk);
        if (wr) begin
            ref_mem[d][a] = wd;
            exp_wdata[d]  = wd;
        end
        #1;
        if (busy) begin
            req_write[d] = 1'b0;
            req_addr[d]  = busy_a;
            req_wdata[d] = DW'($urandom);
        end else begin
            req_valid[d] = 1'b0;
            req_wdata[d] = DW'($urandom);
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            strobe = (k > s) && (k <= s + ac);
            idle   = (k == lat);
            if (!wr && k == s + ac + 1) exp_rdata[d] = ref_mem[d][a];
            chk("ce_n", d, 32'(ce_n[d]), 32'(idle));
            chk("we_n", d, 32'(we_n[d]), 32'(!(wr && strobe)));
            chk("oe_n", d, 32'(oe_n[d]), 32'(!(!wr && strobe)));
            chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(!wr && k == s + ac + 1));
            chk("req_ready", d, 32'(req_ready[d]), 32'(idle));
            chk("sram_addr", d, 32'(sram_addr[d]), 32'(a));
            chk("sram_wdata", d, 32'(sram_wdata[d]), 32'(exp_wdata[d]));
            chk("rsp_rdata", d, 32'(rsp_rdata[d]), 32'(exp_rdata[d]));
            chk("strobe_excl", d, 32'((we_n[d] === 1'b0 && oe_n[d] === 1'b0) ||
                                      (ce_n[d] === 1'b1 && (we_n[d] === 1'b0 || oe_n[d] === 1'b0))), 32'd0);
        end
    endtask

    initial begin
        int d, n;
        bit wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;

        do_reset(0, 2);
        do_reset(1, 2);

        // Write then read at address zero
        txn(0, 1'b1, 11'h000, 8'hA5, 1'b0, '0);
        txn(0, 1'b0, 11'h000, 8'h00, 1'b0, '0);

        // Address boundaries
        txn(0, 1'b1, 11'h7FF, 8'h3C, 1'b0, '0);
        txn(0, 1'b1, 11'h001, 8'hC3, 1'b0, '0);
        txn(0, 1'b0, 11'h7FF, 8'h00, 1'b0, '0);
        txn(0, 1'b0, 11'h001, 8'h00, 1'b0, '0);
        txn(0, 1'b0, 11'h000, 8'h00, 1'b0, '0);

        // Read request held throughout a write is taken only at the following IDLE
        txn(0, 1'b1, 11'h100, 8'h5A, 1'b1, 11'h7FF);
        txn(0, 1'b0, 11'h7FF, 8'h00, 1'b0, '0);
        txn(0, 1'b0, 11'h100, 8'h00, 1'b0, '0);

        // Reset during the first ACCESS cycle of a read
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 11'h000;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (S0 + 1) @(negedge clk);
        chk("abort_oe_low", 0, 32'(oe_n[0]), 32'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        chk_pins_reset(0);
        rst[0] = 1'b0;
        exp_wdata[0] = '0;
        exp_rdata[0] = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 0, 32'(rsp_valid[0]), 32'd0);
        end
        chk("abort_ready", 0, 32'(req_ready[0]), 32'd1);
        chk("abort_rdata", 0, 32'(rsp_rdata[0]), 32'd0);
        txn(0, 1'b0, 11'h000, 8'h00, 1'b0, '0);

        // Stretched timing instance
        txn(1, 1'b1, 11'h000, 8'hA5, 1'b0, '0);
        txn(1, 1'b0, 11'h000, 8'h00, 1'b0, '0);
        txn(1, 1'b1, 11'h7FF, 8'h3C, 1'b0, '0);
        txn(1, 1'b0, 11'h7FF, 8'h00, 1'b0, '0);
        txn(1, 1'b1, 11'h002, 8'h77, 1'b1, 11'h000);
        txn(1, 1'b0, 11'h000, 8'h00, 1'b0, '0);

        // Random mix on both instances against the reference memories
        for (int i = 0; i < 60; i++) begin
            d  = i % 2;
            wr = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(0, 3));
            a  = (n == 0) ? AW'($urandom_range(0, 2047)) : AW'($urandom_range(0, 7));
            wd = DW'($urandom);
            txn(d, wr, a, wd, 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
